// File: rtl/stm32_bus_master_if.sv
// -----------------------------------------------------------------------------
// stm32_bus_master_if
// Groups the command, write-FIFO, read-return and DATA_SYNC/DATA_BUS signals of
// the STM32-side bus master so they travel as one port.
//
// Signals (direction as seen from the master modport):
//   cmd_valid  in   request a transaction (accepted when cmd_valid & cmd_ready)
//   cmd_ready  out  master is idle and can take a command
//   cmd_code   in   command byte sent in the SYNC cycle
//   cmd_dir    in   0 = write payload, 1 = read payload
//   cmd_len    in   payload byte count (clamped to MAX_LEN by the master)
//   wr_data    in   payload byte to queue in the write FIFO
//   wr_valid   in   push strobe (push when wr_valid & wr_ready)
//   wr_ready   out  write FIFO has room
//   rd_data    out  captured read byte
//   rd_valid   out  one-cycle pulse per captured read byte
//   busy       out  a transaction is in progress
//   done       out  one-cycle pulse at the end of a transaction
//   DATA_SYNC  out  frame strobe to the responder
//   bus_out    out  value the master drives onto DATA_BUS
//   bus_oe     out  1 = master drives DATA_BUS
//   bus_in     in   sampled DATA_BUS
// -----------------------------------------------------------------------------
interface stm32_bus_master_if #(
    parameter int LEN_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_code;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             DATA_SYNC;
    logic [7:0]       bus_out;
    logic             bus_oe;
    logic [7:0]       bus_in;

    modport master (
        input  cmd_valid, cmd_code, cmd_dir, cmd_len, wr_data, wr_valid, bus_in,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               DATA_SYNC, bus_out, bus_oe
    );

    modport slave (
        output cmd_valid, cmd_code, cmd_dir, cmd_len, wr_data, wr_valid, bus_in,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               DATA_SYNC, bus_out, bus_oe
    );
endinterface

// File: rtl/stm32_bus_master.sv
// -----------------------------------------------------------------------------
// stm32_bus_master
// Initiator end of the 8-bit DATA_SYNC/DATA_BUS link. Each accepted command
// produces one frame: a SYNC cycle carrying the command byte, then exactly
// len payload bytes, one per clock, either driven from the write FIFO (write)
// or captured from bus_in (read). Writes do not start until the FIFO holds
// the whole payload, because the responder cannot be stalled mid-frame.
//
// Ports:
//   clk_in    in   bus clock, all logic on posedge
//   reset_in  in   synchronous active-high reset; aborts any frame in flight
//   bus_if    master modport of stm32_bus_master_if (command, write FIFO,
//             read return, DATA_SYNC, bus_out/bus_oe/bus_in)
//
// Parameters:
//   MAX_LEN    write FIFO depth and maximum payload bytes per transaction
//   LEN_W      width of length/fill/count registers; must hold MAX_LEN
//   READ_SKIP  idle turnaround cycles between SYNC and the first read capture
// -----------------------------------------------------------------------------
module stm32_bus_master #(
    parameter int MAX_LEN   = 32,
    parameter int LEN_W     = 6,
    parameter int READ_SKIP = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    stm32_bus_master_if.master   bus_if
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] SKIP_LAST_C = LEN_W'((READ_SKIP > 0) ? (READ_SKIP - 1) : 0);
    localparam logic [PTR_W-1:0] PTR_LAST_C  = PTR_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_ZERO_C  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE_C   = LEN_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO_C  = {PTR_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SYNC      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_TURN      = 3'd4,
        ST_READ      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Circular FIFO pointer advance; MAX_LEN need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST_C) begin
            nxt = PTR_ZERO_C;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       code_q, code_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [7:0]       fifo_mem_q [MAX_LEN];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] fill_q, fill_d;

    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             push_s;
    logic             pop_s;
    logic             capture_s;
    logic [LEN_W-1:0] cmd_len_clamped_s;

    // FIFO push/pop qualifiers and command length clamp.
    always_comb begin
        push_s    = bus_if.wr_valid & (fill_q < MAX_LEN_C);
        // Only the WRITE phase consumes FIFO bytes; the empty guard is defensive,
        // a write never enters WRITE without len bytes already queued.
        pop_s     = (state_q == ST_WRITE) && (fill_q != LEN_ZERO_C);
        // READ lasts len+1 cycles: len capture cycles, then one cycle that lets
        // the last rd_valid pulse go out before DONE.
        capture_s = (state_q == ST_READ) && (cnt_q < len_q);
        if (bus_if.cmd_len > MAX_LEN_C) begin
            cmd_len_clamped_s = MAX_LEN_C;
        end else begin
            cmd_len_clamped_s = bus_if.cmd_len;
        end
    end

    // FIFO pointer and fill next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            fill_d = fill_q + LEN_ONE_C;
        end else if (!push_s && pop_s) begin
            fill_d = fill_q - LEN_ONE_C;
        end else begin
            fill_d = fill_q;
        end
    end

    // Transaction FSM next-state, command latch and phase counter.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dir_d   = dir_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.cmd_valid) begin
                    code_d = bus_if.cmd_code;
                    dir_d  = bus_if.cmd_dir;
                    len_d  = cmd_len_clamped_s;
                    cnt_d  = LEN_ZERO_C;
                    if (!bus_if.cmd_dir && (fill_q < cmd_len_clamped_s)) begin
                        state_d = ST_WAIT_DATA;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                // Count a push landing this cycle so SYNC follows the cycle in
                // which the last needed byte is pushed.
                if ((fill_q + LEN_W'(push_s)) >= len_q) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_SYNC: begin
                cnt_d = LEN_ZERO_C;
                if (len_q == LEN_ZERO_C) begin
                    state_d = ST_DONE;
                end else if (!dir_q) begin
                    state_d = ST_WRITE;
                end else if (READ_SKIP == 0) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_TURN;
                end
            end
            ST_WRITE: begin
                if (cnt_q == (len_q - LEN_ONE_C)) begin
                    state_d = ST_DONE;
                    cnt_d   = LEN_ZERO_C;
                end else begin
                    cnt_d   = cnt_q + LEN_ONE_C;
                end
            end
            ST_TURN: begin
                if (cnt_q == SKIP_LAST_C) begin
                    state_d = ST_READ;
                    cnt_d   = LEN_ZERO_C;
                end else begin
                    cnt_d   = cnt_q + LEN_ONE_C;
                end
            end
            ST_READ: begin
                if (cnt_q == len_q) begin
                    state_d = ST_DONE;
                    cnt_d   = LEN_ZERO_C;
                end else begin
                    cnt_d   = cnt_q + LEN_ONE_C;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read return path: register the byte sampled in each capture cycle.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (capture_s) begin
            rd_data_d  = bus_if.bus_in;
            rd_valid_d = 1'b1;
        end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
    end

    // Control, counter, FIFO bookkeeping and read-return registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            code_q     <= 8'h00;
            dir_q      <= 1'b0;
            len_q      <= LEN_ZERO_C;
            cnt_q      <= LEN_ZERO_C;
            wr_ptr_q   <= PTR_ZERO_C;
            rd_ptr_q   <= PTR_ZERO_C;
            fill_q     <= LEN_ZERO_C;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            dir_q      <= dir_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= bus_if.wr_data;
        end
    end

    // Bus and status outputs decoded from registered state only.
    always_comb begin
        bus_if.cmd_ready = (state_q == ST_IDLE);
        bus_if.busy      = (state_q != ST_IDLE);
        bus_if.done      = (state_q == ST_DONE);
        bus_if.DATA_SYNC = (state_q == ST_SYNC);
        bus_if.bus_oe    = (state_q == ST_SYNC) || (state_q == ST_WRITE);
        bus_if.wr_ready  = (fill_q < MAX_LEN_C);
        bus_if.rd_data   = rd_data_q;
        bus_if.rd_valid  = rd_valid_q;
        case (state_q)
            ST_SYNC:  bus_if.bus_out = code_q;
            ST_WRITE: bus_if.bus_out = fifo_mem_q[rd_ptr_q];
            default:  bus_if.bus_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_stm32_bus_master.sv
// -----------------------------------------------------------------------------
// tb_stm32_bus_master
// Self-checking bench for stm32_bus_master. The reference is a byte queue of
// what has been pushed plus the frame timeline expressed as cycle offsets from
// the SYNC cycle (C0): writes drive C1..Clen and finish at Clen+1, reads pulse
// rd_valid at C(2+READ_SKIP+i) with the byte driven in C(1+READ_SKIP+i) and
// finish one cycle after the last pulse, zero-length frames finish at C1.
// -----------------------------------------------------------------------------
module tb_stm32_bus_master;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int RS      = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stm32_bus_master_if #(.LEN_W(LEN_W)) bif ();

    stm32_bus_master #(
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W),
        .READ_SKIP (RS)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus_if   (bif)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_q [$];
    logic [7:0] bin [0:63];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one byte; the queue size predicts wr_ready.
    task automatic push_byte(input logic [7:0] b);
        logic exp_rdy;
        exp_rdy = (model_q.size() < MAX_LEN);
        tests++;
        if (bif.wr_ready !== exp_rdy) begin
            fails++;
            $display("FAIL push_wr_ready: got %b want %b (queued %0d)", bif.wr_ready, exp_rdy, model_q.size());
        end
        bif.wr_valid = 1'b1;
        bif.wr_data  = b;
        if (exp_rdy) model_q.push_back(b);
        step();
        bif.wr_valid = 1'b0;
    endtask

    // One complete transaction from an IDLE cycle through the following IDLE cycle.
    task automatic run_txn(input logic [7:0] code, input logic dir, input int len_req, input int push_pct);
        int         len;
        int         endk;
        int         waited;
        bit         waiting;
        bit         do_push;
        logic       exp_rdy;
        logic       exp_oe;
        logic       exp_rv;
        logic       exp_sync;
        logic       exp_done;
        logic [7:0] exp_out;
        len = (len_req > MAX_LEN) ? MAX_LEN : len_req;
        if (len == 0)        endk = 1;
        else if (dir == 1'b0) endk = len + 1;
        else                  endk = 2 + RS + len;

        tests++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0) begin
            fails++;
            $display("FAIL txn_idle: cmd_ready=%b busy=%b want 1/0", bif.cmd_ready, bif.busy);
        end
        bif.cmd_valid = 1'b1;
        bif.cmd_code  = code;
        bif.cmd_dir   = dir;
        bif.cmd_len   = LEN_W'(len_req);
        waiting = (dir == 1'b0) && (model_q.size() < len);
        step();
        bif.cmd_valid = 1'b0;
        bif.cmd_code  = 8'($urandom);
        bif.cmd_dir   = 1'($urandom);
        bif.cmd_len   = LEN_W'($urandom);

        waited = 0;
        while (waiting) begin
            tests++;
            if (bif.DATA_SYNC !== 1'b0 || bif.bus_oe !== 1'b0 || bif.busy !== 1'b1 ||
                bif.cmd_ready !== 1'b0 || bif.done !== 1'b0 || bif.rd_valid !== 1'b0) begin
                fails++;
                $display("FAIL txn_wait: sync=%b oe=%b busy=%b rdy=%b done=%b rv=%b want 0/0/1/0/0/0",
                         bif.DATA_SYNC, bif.bus_oe, bif.busy, bif.cmd_ready, bif.done, bif.rd_valid);
            end
            exp_rdy = (model_q.size() < MAX_LEN);
            do_push = ($urandom_range(0, 99) < 60);
            bif.wr_valid = do_push;
            bif.wr_data  = 8'($urandom);
            if (do_push && exp_rdy) model_q.push_back(bif.wr_data);
            bif.bus_in = 8'($urandom);
            step();
            bif.wr_valid = 1'b0;
            waited++;
            if (model_q.size() >= len) begin
                waiting = 1'b0;
            end else if (waited > 400) begin
                tests++;
                fails++;
                $display("FAIL txn_wait_timeout: still waiting after %0d cycles, queued %0d want %0d",
                         waited, model_q.size(), len);
                return;
            end
        end

        for (int k = 0; k <= endk; k++) begin
            exp_sync = (k == 0);
            exp_oe   = (k == 0) || (dir == 1'b0 && k >= 1 && k <= len);
            exp_rv   = (dir == 1'b1) && (k >= 2 + RS) && (k <= 1 + RS + len);
            exp_done = (k == endk);
            exp_out  = 8'h00;
            if (k == 0) begin
                exp_out = code;
            end else if (exp_oe) begin
                if (model_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL txn_model_empty: payload cycle %0d has no queued byte", k);
                end else begin
                    exp_out = model_q[0];
                end
            end
            tests++;
            if (bif.DATA_SYNC !== exp_sync || bif.bus_oe !== exp_oe || bif.done !== exp_done ||
                bif.rd_valid !== exp_rv || bif.busy !== 1'b1 || bif.cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL txn_ctrl C%0d: sync=%b oe=%b done=%b rv=%b busy=%b rdy=%b want %b/%b/%b/%b/1/0",
                         k, bif.DATA_SYNC, bif.bus_oe, bif.done, bif.rd_valid, bif.busy, bif.cmd_ready,
                         exp_sync, exp_oe, exp_done, exp_rv);
            end
            if (exp_oe) begin
                tests++;
                if (bif.bus_out !== exp_out) begin
                    fails++;
                    $display("FAIL txn_bus_out C%0d: got %h want %h", k, bif.bus_out, exp_out);
                end
            end
            if (exp_rv) begin
                tests++;
                if (bif.rd_data !== bin[k-1]) begin
                    fails++;
                    $display("FAIL txn_rd_data C%0d: got %h want %h", k, bif.rd_data, bin[k-1]);
                end
            end
            exp_rdy = (model_q.size() < MAX_LEN);
            tests++;
            if (bif.wr_ready !== exp_rdy) begin
                fails++;
                $display("FAIL txn_wr_ready C%0d: got %b want %b", k, bif.wr_ready, exp_rdy);
            end
            bif.bus_in = 8'($urandom);
            bin[k]     = bif.bus_in;
            do_push = ($urandom_range(0, 99) < push_pct);
            bif.wr_valid = do_push;
            bif.wr_data  = 8'($urandom);
            if (dir == 1'b0 && k >= 1 && k <= len && model_q.size() > 0) void'(model_q.pop_front());
            if (do_push && exp_rdy) model_q.push_back(bif.wr_data);
            step();
            bif.wr_valid = 1'b0;
        end

        tests++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.bus_oe !== 1'b0) begin
            fails++;
            $display("FAIL txn_end: rdy=%b busy=%b done=%b oe=%b want 1/0/0/0",
                     bif.cmd_ready, bif.busy, bif.done, bif.bus_oe);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_code  = 8'h00;
        bif.cmd_dir   = 1'b0;
        bif.cmd_len   = '0;
        bif.wr_valid  = 1'b0;
        bif.wr_data   = 8'h00;
        bif.bus_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0 || bif.DATA_SYNC !== 1'b0 || bif.bus_oe !== 1'b0 ||
            bif.bus_out !== 8'h00 || bif.rd_data !== 8'h00 || bif.rd_valid !== 1'b0 ||
            bif.done !== 1'b0 || bif.wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: rdy=%b busy=%b sync=%b oe=%b out=%h rd=%h rv=%b done=%b wrdy=%b",
                     bif.cmd_ready, bif.busy, bif.DATA_SYNC, bif.bus_oe, bif.bus_out, bif.rd_data,
                     bif.rd_valid, bif.done, bif.wr_ready);
        end
    endtask

    task automatic test_write_basic();
        push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
        push_byte(8'hAB); push_byte(8'hCD); push_byte(8'hEF);
        run_txn(8'h03, 1'b0, 6, 0);
    endtask

    task automatic test_read_basic();
        run_txn(8'h08, 1'b1, 3, 0);
    endtask

    task automatic test_zero_len();
        run_txn(8'h05, 1'b0, 0, 0);
        run_txn(8'h06, 1'b1, 0, 0);
    endtask

    task automatic test_wait_data();
        for (int i = 0; i < 10; i++) push_byte(8'($urandom));
        run_txn(8'h01, 1'b0, 21, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < MAX_LEN; i++) push_byte(8'($urandom));
        tests++;
        if (bif.wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_full: wr_ready got %b want 0", bif.wr_ready);
        end
        bif.cmd_valid = 1'b1;
        bif.cmd_code  = 8'h08;
        bif.cmd_dir   = 1'b1;
        bif.cmd_len   = LEN_W'(10);
        step();
        bif.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bif.bus_in = 8'($urandom);
            step();
        end
        tests++;
        if (bif.rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_c3_rv: got %b want 1", bif.rd_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
        tests++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0 || bif.bus_oe !== 1'b0 || bif.DATA_SYNC !== 1'b0 ||
            bif.rd_valid !== 1'b0 || bif.done !== 1'b0 || bif.wr_ready !== 1'b1 || bif.rd_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_state: rdy=%b busy=%b oe=%b sync=%b rv=%b done=%b wrdy=%b rd=%h",
                     bif.cmd_ready, bif.busy, bif.bus_oe, bif.DATA_SYNC, bif.rd_valid, bif.done,
                     bif.wr_ready, bif.rd_data);
        end
        for (int k = 0; k < 12; k++) begin
            bif.bus_in = 8'($urandom);
            step();
            tests++;
            if (bif.rd_valid !== 1'b0 || bif.done !== 1'b0 || bif.busy !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_quiet %0d: rv=%b done=%b busy=%b want 0/0/0",
                         k, bif.rd_valid, bif.done, bif.busy);
            end
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < MAX_LEN + 1; i++) push_byte(8'(i + 1));
        run_txn(8'h22, 1'b0, 32, 50);
        run_txn(8'h23, 1'b0, 40, 30);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 25; n++) begin
            run_txn(8'($urandom), 1'($urandom), $urandom_range(0, 40), $urandom_range(0, 80));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_zero_len();
        test_wait_data();
        test_reset_mid();
        test_fifo_full();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
